// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low key matrix scanner with a row synchroniser, whole-scan debounce
// and registered one-hot key outputs.
module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] keys,
    output logic        key_valid,
    output logic        multi_key
);

    localparam int unsigned STW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(SCAN_DIV - 1);
    localparam logic [STW-1:0]   StableMax = STW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {StCol0, StCol1, StCol2, StCol3} col_e;

    col_e             col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       row_meta_q, row_sync_q, rows_pressed;
    logic [15:0]      raw_q, raw_d, prev_q, prev_d, deb_q, deb_d, scan_vec;
    logic [15:0]      keys_d;
    logic [STW-1:0]   stable_q, stable_d;
    logic             key_valid_d, multi_key_d, slot_end, scan_end, deb_onehot;

    assign rows_pressed = ~row_sync_q;
    assign slot_end     = (cnt_q == CntLast);
    assign scan_end     = slot_end && (col_q == StCol3);

    // Column FSM and slot counter
    always_comb begin
        col_d   = col_q;
        cnt_d   = cnt_q + CNT_W'(1);
        col_out = 4'b1110;
        unique case (col_q)
            StCol0: col_out = 4'b1110;
            StCol1: col_out = 4'b1101;
            StCol2: col_out = 4'b1011;
            StCol3: col_out = 4'b0111;
        endcase
        if (slot_end) begin
            cnt_d = '0;
            unique case (col_q)
                StCol0: col_d = StCol1;
                StCol1: col_d = StCol2;
                StCol2: col_d = StCol3;
                StCol3: col_d = StCol0;
            endcase
        end
    end

    // Scan assembly and debounce; scan_vec already holds the rows of the current column
    always_comb begin
        raw_d    = raw_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        deb_d    = deb_q;
        scan_vec = raw_q;
        unique case (col_q)
            StCol0: scan_vec[3:0]   = rows_pressed;
            StCol1: scan_vec[7:4]   = rows_pressed;
            StCol2: scan_vec[11:8]  = rows_pressed;
            StCol3: scan_vec[15:12] = rows_pressed;
        endcase
        if (slot_end) begin
            raw_d = scan_vec;
        end
        if (scan_end) begin
            if (scan_vec != prev_q) begin
                prev_d   = scan_vec;
                stable_d = '0;
            end else if (stable_q < StableMax) begin
                stable_d = stable_q + STW'(1);
                if (stable_d == StableMax) begin
                    deb_d = scan_vec;
                end
            end
        end
    end

    always_comb begin
        deb_onehot  = (deb_q != '0) && ((deb_q & (deb_q - 16'd1)) == '0);
        keys_d      = deb_onehot ? deb_q : '0;
        multi_key_d = (deb_q != '0) && !deb_onehot;
        key_valid_d = (keys_d != keys) && (keys_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q      <= StCol0;
            cnt_q      <= '0;
            row_meta_q <= '0;
            row_sync_q <= '0;
            raw_q      <= '0;
            prev_q     <= '0;
            stable_q   <= '0;
            deb_q      <= '0;
            keys       <= '0;
            key_valid  <= 1'b0;
            multi_key  <= 1'b0;
        end else begin
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
            raw_q      <= raw_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            deb_q      <= deb_d;
            keys       <= keys_d;
            key_valid  <= key_valid_d;
            multi_key  <= multi_key_d;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a key-matrix model drives row_in from col_out,
// expected key_valid captures are queued by the stimulus and popped by a monitor.
module tb_keypad_matrix_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned LAT      = (DEB + 2) * 4 * SCAN_DIV + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in, col_out;
    logic [15:0] keys, key_mask, mon_exp;
    logic        key_valid, multi_key;
    logic [3:0]  exp_col;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] sb[$];

    keypad_matrix_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .keys      (keys),
        .key_valid (key_valid),
        .multi_key (multi_key)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_out[c] && key_mask[c*4+r]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && key_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_key_valid: got keys %0h expected no pulse", keys);
            end else begin
                mon_exp = sb.pop_front();
                check("kv_keys", {16'h0, keys}, {16'h0, mon_exp});
                check("kv_multi", {31'h0, multi_key}, 32'h0);
            end
        end
    end

    task automatic wait_keys(input logic [15:0] exp, input string name);
        for (int i = 0; i < LAT; i++) begin
            if (keys === exp) break;
            @(negedge clk);
        end
        check(name, {16'h0, keys}, {16'h0, exp});
    endtask

    task automatic wait_multi(input string name);
        for (int i = 0; i < LAT; i++) begin
            if (multi_key === 1'b1) break;
            @(negedge clk);
        end
        check(name, {31'h0, multi_key}, 32'h1);
    endtask

    initial begin
        key_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_col", {28'h0, col_out}, 32'hE);
        check("rst_keys", {16'h0, keys}, 32'h0);
        check("rst_kv", {31'h0, key_valid}, 32'h0);
        check("rst_multi", {31'h0, multi_key}, 32'h0);
        reset = 1'b0;

        // Idle walk: each column held for SCAN_DIV cycles
        for (int k = 0; k < 100; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("walk_col", {28'h0, col_out}, {28'h0, exp_col});
            check("walk_keys", {16'h0, keys}, 32'h0);
            @(negedge clk);
        end

        // Key 9 (column 2, row 1)
        sb.push_back(16'h0200);
        key_mask = 16'h0200;
        wait_keys(16'h0200, "press_key9");
        repeat (20) @(negedge clk);
        check("hold_key9", {16'h0, keys}, 32'h0200);

        key_mask = '0;
        wait_keys(16'h0000, "release_key9");
        check("release_multi", {31'h0, multi_key}, 32'h0);

        // 6-cycle half period: column-2 samples, 16 cycles apart, never agree three scans running
        for (int t = 0; t < 20; t++) begin
            key_mask = key_mask ^ 16'h0200;
            repeat (6) @(negedge clk);
            check("bounce_keys", {16'h0, keys}, 32'h0);
        end
        key_mask = '0;
        repeat (LAT) @(negedge clk);
        check("bounce_settle", {16'h0, keys}, 32'h0);

        // Keys 0 and 15 together, then release 15
        key_mask = 16'h8001;
        wait_multi("two_keys_multi");
        check("two_keys_keys", {16'h0, keys}, 32'h0);
        sb.push_back(16'h0001);
        key_mask = 16'h0001;
        wait_keys(16'h0001, "release_15");
        check("release_15_multi", {31'h0, multi_key}, 32'h0);
        key_mask = '0;
        wait_keys(16'h0000, "release_0");

        // Asynchronous reset in the middle of the column-2 slot
        sb.push_back(16'h0200);
        key_mask = 16'h0200;
        wait_keys(16'h0200, "press_key9_again");
        for (int i = 0; i < 20; i++) begin
            if (col_out === 4'b1011) break;
            @(negedge clk);
        end
        check("pre_reset_col2", {28'h0, col_out}, 32'hB);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_col", {28'h0, col_out}, 32'hE);
        check("midrst_keys", {16'h0, keys}, 32'h0);
        check("midrst_kv", {31'h0, key_valid}, 32'h0);
        check("midrst_multi", {31'h0, multi_key}, 32'h0);
        key_mask = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (LAT) @(negedge clk);
        check("post_reset_keys", {16'h0, keys}, 32'h0);

        check("sb_drain", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
